// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
// Holds the FSM encoding, ID/data widths and the buffered-result record.
package reg_write_arbiter_pkg;

   localparam int REG_ID_W = 5;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [REG_ID_W-1:0] id;
      logic [DATA_W-1:0]   value;
   } wr_entry_t;

   // $0 is hardwired, so an ID of zero never names a real write
   function automatic logic live_id(input logic [REG_ID_W-1:0] id);
      return id != '0;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_result_fifo.sv
// Synchronous FIFO buffering multi-cycle unit results.
// Push is ignored when full, pop is ignored when empty.
module result_fifo
   import reg_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  wr_entry_t                    din,
   output wr_entry_t                    dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wr_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline
// writeback and buffered multi-cycle results, with a pending scoreboard.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wb_valid,
   input  logic [REG_ID_W-1:0] wb_reg_id,
   input  logic [DATA_W-1:0]   wb_value,
   input  logic                mdu_valid,
   input  logic [REG_ID_W-1:0] mdu_reg_id,
   input  logic [DATA_W-1:0]   mdu_value,
   output logic                mdu_ready,
   input  logic                issue_valid,
   input  logic [REG_ID_W-1:0] issue_reg_id,
   input  logic [REG_ID_W-1:0] rs_id,
   input  logic [REG_ID_W-1:0] rt_id,
   output logic                stall,
   output logic                rf_write,
   output logic [REG_ID_W-1:0] rf_write_id,
   output logic [DATA_W-1:0]   rf_write_value
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SV_W  = $clog2(STARVE_LIMIT + 1);

   wr_entry_t   head;
   wr_entry_t   mdu_entry;
   logic        fifo_full;
   logic        fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   logic        wb_sel;
   logic        push;
   logic        pop;
   logic        denied;
   logic        head_write;
   logic        last_pop;
   logic        starve_hit;

   logic [31:0] pending;
   logic [31:0] pending_next;
   logic [SV_W-1:0] starve;

   arb_state_t  state_q;
   arb_state_t  state_d;

   assign mdu_entry = '{id: mdu_reg_id, value: mdu_value};

   result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (mdu_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ready comes from registered occupancy only, never from a same-cycle pop
   assign mdu_ready  = !fifo_full;
   assign push       = mdu_valid && mdu_ready;
   assign wb_sel     = wb_valid && live_id(wb_reg_id);
   assign pop        = !fifo_empty && !wb_sel;
   assign denied     = !fifo_empty && wb_sel;
   assign head_write = pop && live_id(head.id);

   always_comb begin
      rf_write       = 1'b0;
      rf_write_id    = '0;
      rf_write_value = '0;
      if (wb_sel) begin
         rf_write       = 1'b1;
         rf_write_id    = wb_reg_id;
         rf_write_value = wb_value;
      end else if (head_write) begin
         rf_write       = 1'b1;
         rf_write_id    = head.id;
         rf_write_value = head.value;
      end
   end

   // clear applied before set so a same-cycle reissue keeps the bit
   always_comb begin
      pending_next = pending;
      if (head_write) begin
         pending_next[head.id] = 1'b0;
      end
      if (issue_valid && live_id(issue_reg_id)) begin
         pending_next[issue_reg_id] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve <= '0;
      end else if (pop) begin
         starve <= '0;
      end else if (denied && starve != SV_W'(STARVE_LIMIT)) begin
         starve <= starve + SV_W'(1);
      end
   end

   assign last_pop   = pop && !push && (fifo_count == CNT_W'(1));
   assign starve_hit = denied && (starve == SV_W'(STARVE_LIMIT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (push) begin
               state_d = PEND;
            end
         end
         PEND: begin
            if (last_pop) begin
               state_d = IDLE;
            end else if (starve_hit) begin
               state_d = FORCE;
            end
         end
         FORCE: begin
            if (last_pop) begin
               state_d = IDLE;
            end else if (pop) begin
               state_d = PEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall = pending[rs_id] | pending[rt_id] | (state_q == FORCE);

endmodule
